// File: rtl/amiga_daug_dram_ctl.sv
// amiga_daug_dram_ctl
//   Clocked DRAM controller for a 68000 bus. It multiplexes row and column
//   addresses, sequences RAS/CAS with byte-lane CAS, runs queued
//   CAS-before-RAS refresh, gates writes when write protect is set, and
//   generates _DTACK. External latches and buffers are driven by _CDR and _CDW.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   A                 68000 word address, bits [2*ROW_BITS+BANK_BITS:1]
//   SEL               external address decode hit (active high)
//   _AS/_UDS/_LDS     68000 strobes (active low)
//   _PRW              1 = read, 0 = write
//   WP_SET            one-clock pulse that sets write protect
//   MA                multiplexed DRAM address
//   _RAS              per-bank row strobes
//   _CASU/_CASL       byte-lane column strobes
//   _WE               DRAM write enable
//   _CDR/_CDW         read-latch output enable / write-buffer enable
//   _DTACK            cycle acknowledge
//   WPRO              write protect active
//   REF_OVF           sticky flag: a refresh request was lost
module amiga_daug_dram_ctl #(
  parameter int ROW_BITS     = 8,
  parameter int BANKS        = 2,
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 3,
  parameter int REF_INTERVAL = 108
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [2*ROW_BITS+$clog2(BANKS):1] A,
  input  logic                              SEL,
  input  logic                              _AS,
  input  logic                              _UDS,
  input  logic                              _LDS,
  input  logic                              _PRW,
  input  logic                              WP_SET,
  output logic [ROW_BITS-1:0]               MA,
  output logic [BANKS-1:0]                  _RAS,
  output logic                              _CASU,
  output logic                              _CASL,
  output logic                              _WE,
  output logic                              _CDR,
  output logic                              _CDW,
  output logic                              _DTACK,
  output logic                              WPRO,
  output logic                              REF_OVF
);

  localparam int BANK_BITS = $clog2(BANKS);
  localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int CNT_W     = $clog2(T_RCD + T_CAS + T_RP + 1);
  localparam int TMR_W     = $clog2(REF_INTERVAL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_ACK, S_PRE, S_RCAS, S_RRAS
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                wpro_q, wpro_d;
  logic                prot_q, prot_d;
  logic [ROW_BITS-1:0] ma_q, ma_d;
  logic [BANKS-1:0]    ras_n_q, ras_n_d;
  logic                casu_n_q, casu_n_d;
  logic                casl_n_q, casl_n_d;
  logic                we_n_q, we_n_d;
  logic                cdr_n_q, cdr_n_d;
  logic                cdw_n_q, cdw_n_d;
  logic                dtack_n_q, dtack_n_d;

  // Cycle attributes captured at start and held for the whole access
  logic [ROW_BITS-1:0] row_q, col_q;
  logic [BW-1:0]       bank_q;
  logic                rd_q, uds_n_q, lds_n_q;

  logic [BW-1:0]       bank_w;
  logic                start, hold, in_row, in_col, ref_req, ref_done;

  if (BANKS > 1) begin : g_bank
    assign bank_w = A[2*ROW_BITS+BANK_BITS:2*ROW_BITS+1];
  end else begin : g_nobank
    assign bank_w = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    prot_d  = prot_q;
    wpro_d  = wpro_q | WP_SET;

    case (state_q)
      S_IDLE: begin
        // Refresh wins over an access requested in the same clock
        if (pend_q != 2'd0) begin
          state_d = S_RCAS;
        end else if (!_AS && SEL && (!_UDS || !_LDS)) begin
          state_d = S_ROW;
          cnt_d   = CNT_W'(T_RCD - 1);
          start   = 1'b1;
          prot_d  = wpro_q && !_PRW;
        end
      end
      S_ROW: begin
        if (cnt_q == '0) begin
          state_d = S_COL;
          cnt_d   = CNT_W'(T_CAS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_COL: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACK: begin
        if (_AS) begin
          state_d = S_PRE;
          cnt_d   = CNT_W'(T_RP - 1);
        end
      end
      S_PRE: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RCAS: begin
        state_d = S_RRAS;
        cnt_d   = CNT_W'(T_RCD + T_CAS - 1);
      end
      S_RRAS: begin
        if (cnt_q == '0) begin
          state_d = S_PRE;
          cnt_d   = CNT_W'(T_RP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are a registered decode of the current state, so every strobe
    // lags its state entry by one clock. ACK releases on the edge that
    // samples _AS high.
    hold   = (state_q == S_ACK) && !_AS;
    in_row = (state_q == S_ROW) || (state_q == S_COL) || hold;
    in_col = (state_q == S_COL) || hold;

    ma_d      = in_col ? col_q : (in_row ? row_q : '0);
    ras_n_d   = '1;
    casu_n_d  = 1'b1;
    casl_n_d  = 1'b1;
    we_n_d    = 1'b1;
    cdr_n_d   = 1'b1;
    cdw_n_d   = 1'b1;
    dtack_n_d = !hold;

    if (in_row && !prot_q) ras_n_d[bank_q] = 1'b0;
    if (in_row && !rd_q && !prot_q) begin
      we_n_d  = 1'b0;
      cdw_n_d = 1'b0;
    end
    if (in_col && !prot_q) begin
      casu_n_d = uds_n_q;
      casl_n_d = lds_n_q;
    end
    if (in_col && rd_q) cdr_n_d = 1'b0;

    if (state_q == S_RCAS || state_q == S_RRAS) begin
      casu_n_d = 1'b0;
      casl_n_d = 1'b0;
    end
    if (state_q == S_RRAS) ras_n_d = '0;

    // Refresh timer and pending queue; a request coinciding with a
    // completed refresh cancels out.
    ref_req  = (tmr_q == '0);
    tmr_d    = ref_req ? TMR_W'(REF_INTERVAL - 1) : tmr_q - TMR_W'(1);
    ref_done = (state_q == S_RRAS) && (cnt_q == '0);
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    if (ref_req && !ref_done) begin
      if (pend_q == 2'd3) ovf_d  = 1'b1;
      else                pend_d = pend_q + 2'd1;
    end else if (!ref_req && ref_done) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmr_q     <= TMR_W'(REF_INTERVAL - 1);
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      wpro_q    <= 1'b0;
      prot_q    <= 1'b0;
      ma_q      <= '0;
      ras_n_q   <= '1;
      casu_n_q  <= 1'b1;
      casl_n_q  <= 1'b1;
      we_n_q    <= 1'b1;
      cdr_n_q   <= 1'b1;
      cdw_n_q   <= 1'b1;
      dtack_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      wpro_q    <= wpro_d;
      prot_q    <= prot_d;
      ma_q      <= ma_d;
      ras_n_q   <= ras_n_d;
      casu_n_q  <= casu_n_d;
      casl_n_q  <= casl_n_d;
      we_n_q    <= we_n_d;
      cdr_n_q   <= cdr_n_d;
      cdw_n_q   <= cdw_n_d;
      dtack_n_q <= dtack_n_d;
    end
  end

  // Address and strobe capture; only meaningful while an access is active
  always_ff @(posedge CLK) begin
    if (start) begin
      row_q   <= A[2*ROW_BITS:ROW_BITS+1];
      col_q   <= A[ROW_BITS:1];
      bank_q  <= bank_w;
      rd_q    <= _PRW;
      uds_n_q <= _UDS;
      lds_n_q <= _LDS;
    end
  end

  assign MA      = ma_q;
  assign _RAS    = ras_n_q;
  assign _CASU   = casu_n_q;
  assign _CASL   = casl_n_q;
  assign _WE     = we_n_q;
  assign _CDR    = cdr_n_q;
  assign _CDW    = cdw_n_q;
  assign _DTACK  = dtack_n_q;
  assign WPRO    = wpro_q;
  assign REF_OVF = ovf_q;

endmodule
